// File: rtl/spart_pkg.sv
// SPART shared definitions: bus register addresses,
// receiver state encoding and default frame geometry.
package spart_pkg;

  localparam logic [1:0] ADDR_RXTX   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/spart_sync.sv
// Flop chain synchronizer for an async input, resets to 1.
// Ports: clk, rst (async low), d (async in), q (synced out).
module spart_sync
  import spart_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_q <= '1;
    end else begin
      ff_q <= (ff_q << 1) | STAGES'(d);
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/spart_receiver.sv
// SPART receive half: 16x oversampled 8N1 deframer.
// Ports: clk, rst, RxD, BRGEN, IOCS/IORW/IOADDR -> rec_buff, RDA, FE, OE.
module spart_receiver
  import spart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxD,
  input  logic                 BRGEN,
  input  logic                 IOCS,
  input  logic                 IORW,
  input  logic [1:0]           IOADDR,
  output logic [DATA_BITS-1:0] rec_buff,
  output logic                 RDA,
  output logic                 FE,
  output logic                 OE
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_END = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t state_q, state_d;

  logic                 rxs;
  logic                 last_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 wrap;
  logic                 sample;
  logic                 done;
  logic                 fe_set;
  logic                 rd_buf;
  logic                 rd_stat;

  spart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (RxD),
    .q  (rxs)
  );

  assign rd_buf  = IOCS && IORW && (IOADDR == ADDR_RXTX);
  assign rd_stat = IOCS && IORW && (IOADDR == ADDR_STATUS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (BRGEN) begin
      unique case (state_q)
        IDLE:  if (last_q && !rxs) state_d = START;
        START: if (wrap) state_d = rxs ? IDLE : DATA;
        DATA:  if (wrap && bit_q == LAST_BIT) state_d = STOP;
        STOP:  if (wrap) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // wrap marks the sample point of the current bit
  always_comb begin
    wrap   = 1'b0;
    sample = 1'b0;
    done   = 1'b0;
    fe_set = 1'b0;
    unique case (state_q)
      START: wrap = (tick_q == HALF_END);
      DATA: begin
        wrap   = (tick_q == BIT_END);
        sample = BRGEN && wrap;
      end
      STOP: begin
        wrap   = (tick_q == BIT_END);
        done   = BRGEN && wrap && rxs;
        fe_set = BRGEN && wrap && !rxs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b1;
    end else if (BRGEN) begin
      last_q <= rxs;
      tick_q <= (state_q == IDLE || wrap) ? '0 : tick_q + 1'b1;
      if (state_q != DATA) begin
        bit_q <= '0;
      end else if (sample) begin
        bit_q <= bit_q + 1'b1;
      end
      if (sample) begin
        shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
      end
    end
  end

  // completion beats a same-edge buffer read; FE set beats clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_buff <= '0;
      RDA      <= 1'b0;
      FE       <= 1'b0;
      OE       <= 1'b0;
    end else begin
      if (done) begin
        rec_buff <= shift_q;
        RDA      <= 1'b1;
      end else if (rd_buf) begin
        RDA <= 1'b0;
      end
      if (rd_buf) begin
        OE <= 1'b0;
      end else if (done && RDA) begin
        OE <= 1'b1;
      end
      if (fe_set) begin
        FE <= 1'b1;
      end else if (rd_stat) begin
        FE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spart_receiver.sv
// Randomised bench for spart_receiver against a
// tick-index frame model of the 8N1 receiver.
module tb_spart_receiver;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int SS = 2;
  localparam int STOP_K = OS * (DB + 1) + OS / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          RxD;
  logic          BRGEN;
  logic          IOCS;
  logic          IORW;
  logic [1:0]    IOADDR;
  logic [DB-1:0] rec_buff;
  logic          RDA;
  logic          FE;
  logic          OE;

  int n_checks = 0;
  int n_errors = 0;

  spart_receiver #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .SYNC_STAGES(SS)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .RxD     (RxD),
    .BRGEN   (BRGEN),
    .IOCS    (IOCS),
    .IORW    (IORW),
    .IOADDR  (IOADDR),
    .rec_buff(rec_buff),
    .RDA     (RDA),
    .FE      (FE),
    .OE      (OE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // model: rxs delay line, frame position in ticks
  bit          sq[$];
  logic        m_prev = 1'b1;
  logic        m_active = 1'b0;
  int          m_k = 0;
  logic [DB-1:0] m_data = '0;
  logic [DB-1:0] m_buf = '0;
  logic        m_rda = 1'b0;
  logic        m_fe = 1'b0;
  logic        m_oe = 1'b0;

  task automatic model_reset();
    sq.delete();
    for (int i = 0; i < SS; i++) sq.push_back(1'b1);
    m_prev   = 1'b1;
    m_active = 1'b0;
    m_k      = 0;
    m_data   = '0;
    m_buf    = '0;
    m_rda    = 1'b0;
    m_fe     = 1'b0;
    m_oe     = 1'b0;
  endtask

  task automatic model_step();
    bit rxs_m;
    bit rd_b;
    bit rd_s;
    bit done;
    bit fe_ev;
    int n;
    rxs_m = sq.pop_front();
    sq.push_back(RxD);
    rd_b  = IOCS && IORW && IOADDR == 2'b00;
    rd_s  = IOCS && IORW && IOADDR == 2'b01;
    done  = 0;
    fe_ev = 0;
    if (BRGEN) begin
      if (!m_active) begin
        if (m_prev && !rxs_m) begin
          m_active = 1'b1;
          m_k      = 0;
        end
      end else begin
        m_k++;
        if (m_k == OS / 2) begin
          if (rxs_m) m_active = 1'b0;
        end else if (m_k > OS / 2 &&
                     (m_k - OS / 2) % OS == 0) begin
          n = (m_k - OS / 2) / OS;
          if (n <= DB) begin
            m_data[n-1] = rxs_m;
          end else begin
            m_active = 1'b0;
            if (rxs_m) done = 1;
            else fe_ev = 1;
          end
        end
      end
      m_prev = rxs_m;
    end
    if (done) begin
      if (rd_b) m_oe = 1'b0;
      else if (m_rda) m_oe = 1'b1;
      m_buf = m_data;
      m_rda = 1'b1;
    end else if (rd_b) begin
      m_rda = 1'b0;
      m_oe  = 1'b0;
    end
    if (fe_ev) m_fe = 1'b1;
    else if (rd_s) m_fe = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("rec_buff", 32'(rec_buff), 32'(m_buf));
      check("RDA", 32'(RDA), 32'(m_rda));
      check("FE", 32'(FE), 32'(m_fe));
      check("OE", 32'(OE), 32'(m_oe));
    end
  end

  // stimulus state
  logic line = 1'b1;
  int   brg_div = 1;
  int   brg_cnt = 0;
  int   rd_req = -1;
  bit   rnd_bus = 0;
  bit   auto_rd = 0;
  bit   auto_hit = 0;

  task automatic clk_step();
    @(negedge clk);
    BRGEN   = (brg_cnt == 0);
    brg_cnt = (brg_cnt + 1) % brg_div;
    RxD     = line;
    IOCS    = 1'b0;
    IORW    = 1'b0;
    IOADDR  = 2'b00;
    if (rd_req >= 0) begin
      IOCS   = 1'b1;
      IORW   = 1'b1;
      IOADDR = 2'(rd_req);
      rd_req = -1;
    end else if (rnd_bus && $urandom_range(0, 15) == 0) begin
      IOCS   = 1'($urandom_range(0, 1));
      IORW   = 1'($urandom_range(0, 1));
      IOADDR = 2'($urandom_range(0, 3));
    end
    if (auto_rd && BRGEN && m_active && m_k == STOP_K - 1) begin
      IOCS     = 1'b1;
      IORW     = 1'b1;
      IOADDR   = 2'b00;
      auto_hit = 1;
    end
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) clk_step();
  endtask

  task automatic send(input logic [DB-1:0] d,
                      input logic stop,
                      input int rst_at);
    logic [DB+1:0] fr;
    int cnt;
    fr  = {stop, d, 1'b0};
    cnt = 0;
    for (int i = 0; i < DB + 2; i++) begin
      for (int c = 0; c < OS * brg_div; c++) begin
        line = fr[i];
        clk_step();
        cnt++;
        if (rst_at > 0 && cnt == rst_at) begin
          rst = 1'b0;
          #1;
          check("rst_buff", 32'(rec_buff), 0);
          check("rst_RDA", 32'(RDA), 0);
          check("rst_FE", 32'(FE), 0);
          check("rst_OE", 32'(OE), 0);
        end
        if (rst_at > 0 && cnt == rst_at + 3) rst = 1'b1;
      end
    end
    idle(OS * brg_div);
  endtask

  task automatic bus_read(input int addr);
    rd_req = addr;
    clk_step();
    clk_step();
  endtask

  initial begin
    rst    = 1'b0;
    RxD    = 1'b1;
    BRGEN  = 1'b0;
    IOCS   = 1'b0;
    IORW   = 1'b0;
    IOADDR = 2'b00;
    repeat (3) clk_step();
    check("reset_buff", 32'(rec_buff), 0);
    check("reset_RDA", 32'(RDA), 0);
    check("reset_FE", 32'(FE), 0);
    check("reset_OE", 32'(OE), 0);
    rst = 1'b1;
    idle(20);

    send(8'hAA, 1'b1, 0);
    check("aa_buff", 32'(rec_buff), 32'h AA);
    check("aa_RDA", 32'(RDA), 1);
    check("aa_FE", 32'(FE), 0);
    check("aa_OE", 32'(OE), 0);
    bus_read(0);
    check("aa_rd_RDA", 32'(RDA), 0);

    send(8'h55, 1'b1, 0);
    send(8'h3C, 1'b1, 0);
    check("ov_buff", 32'(rec_buff), 32'h3C);
    check("ov_RDA", 32'(RDA), 1);
    check("ov_OE", 32'(OE), 1);
    bus_read(0);
    check("ov_rd_RDA", 32'(RDA), 0);
    check("ov_rd_OE", 32'(OE), 0);

    send(8'h81, 1'b0, 0);
    check("fe_FE", 32'(FE), 1);
    check("fe_RDA", 32'(RDA), 0);
    check("fe_buff", 32'(rec_buff), 32'h3C);
    bus_read(1);
    check("fe_rd_FE", 32'(FE), 0);

    line = 1'b0;
    repeat (4) clk_step();
    idle(40);
    check("gl_RDA", 32'(RDA), 0);
    check("gl_FE", 32'(FE), 0);
    send(8'h0F, 1'b1, 0);
    check("gl_buff", 32'(rec_buff), 32'h0F);
    check("gl_RDA2", 32'(RDA), 1);

    send(8'hFF, 1'b1, OS * 4 + OS / 2);
    idle(20);
    check("rs_RDA", 32'(RDA), 0);
    send(8'h12, 1'b1, 0);
    check("rs_buff", 32'(rec_buff), 32'h12);

    brg_div = 4;
    brg_cnt = 0;
    auto_rd = 1;
    send(8'hC3, 1'b1, 0);
    auto_rd = 0;
    check("sim_hit", 32'(auto_hit), 1);
    check("sim_buff", 32'(rec_buff), 32'hC3);
    check("sim_RDA", 32'(RDA), 1);
    check("sim_OE", 32'(OE), 0);

    rnd_bus = 1;
    for (int f = 0; f < 14; f++) begin
      brg_div = 1 << $urandom_range(0, 2);
      brg_cnt = 0;
      if ($urandom_range(0, 5) == 0) begin
        line = 1'b0;
        repeat ($urandom_range(1, 6)) clk_step();
        idle(OS * brg_div);
      end
      send(8'($urandom), 1'($urandom_range(0, 4) != 0), 0);
      idle($urandom_range(0, 30));
    end
    rnd_bus = 0;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spart_receiver.md
Name: spart_receiver

Overview:
- Serial receive half of the SPART; the counterpart of the transmitter.
- Samples the asynchronous RxD line using the shared baud-rate-generator enable (BRGEN, 16x oversample).
- Deframes 8N1 characters (1 start bit, DATA_BITS data bits LSB first, 1 stop bit) into a receive buffer.
- Presents the received byte and status flags to the bus-interface side through the IOCS/IORW/IOADDR handshake.

Parameters:
- DATA_BITS, 8, number of data bits per frame.
- OVERSAMPLE, 16, BRGEN ticks per bit period (must be even, 4 or more).
- SYNC_STAGES, 2, flops in the RxD synchronizer.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low; all flops reset while rst = 0.
- RxD  input  1  serial data line, asynchronous to clk, idles high.
- BRGEN  input  1  one-clk-wide pulse at OVERSAMPLE x baud rate.
- IOCS  input  1  chip select from the bus interface.
- IORW  input  1  1 = read, 0 = write.
- IOADDR  input  2  register select: 2'b00 = receive buffer, 2'b01 = status.
- rec_buff  output  DATA_BITS  last correctly framed byte.
- RDA  output  1  receive data available.
- FE  output  1  framing error (stop bit sampled 0).
- OE  output  1  overrun (byte completed while RDA = 1).

Behaviour:
- Reset (rst = 0, async): rec_buff = 0, RDA = 0, FE = 0, OE = 0, state = IDLE, synchronizer flops = 1, tick counter = 0, bit counter = 0.
- RxD passes through SYNC_STAGES flops. All decisions use the synchronized value rxs.
- Ticks: the counter advances only on clk edges where BRGEN = 1. States hold otherwise.
- IDLE:
  - rxs = 0 seen on a tick -> START, tick counter cleared.
- START:
  - At tick OVERSAMPLE/2 (mid start bit), sample rxs.
  - rxs = 0 -> DATA; tick and bit counters cleared.
  - rxs = 1 -> false start, return to IDLE with no flag change.
- DATA:
  - Every OVERSAMPLE ticks, sample rxs into the shift register MSB, shifting right (LSB-first reconstruction).
  - After DATA_BITS samples -> STOP.
- STOP:
  - After OVERSAMPLE ticks, sample rxs.
  - rxs = 1: rec_buff <= shift register, RDA <= 1. If RDA was already 1 and is not being cleared this cycle, OE <= 1.
  - rxs = 0: FE <= 1; rec_buff and RDA unchanged.
  - Either outcome -> IDLE. A held-low line is not re-armed until rxs returns to 1 (IDLE requires a 1->0 transition, tracked by a last-rxs flop).
- Latency: RDA/rec_buff update on the clk edge of the stop-bit sample tick. A read in the following cycle sees the new data.
- Reads (combinational decode, effect on the next clk edge):
  - IOCS = 1, IORW = 1, IOADDR = 00: clears RDA and OE.
  - IOCS = 1, IORW = 1, IOADDR = 01: clears FE.
  - Writes and IOADDR 10/11 have no effect on this block.
- Simultaneous events:
  - Buffer read on the same edge a new byte completes: the new byte wins, RDA stays 1, OE not set.
  - Status read on the same edge a framing error occurs: FE = 1 (set wins).
- Reset mid-frame: the partial character is discarded and the block returns to IDLE.
- The bit counter is sized clog2(DATA_BITS+1). The tick counter is clog2(OVERSAMPLE) wide and wraps to 0 at each sample point.

Decomposition:
- spart_pkg holds:
  - IOADDR constants (ADDR_RXTX = 2'b00, ADDR_STATUS = 2'b01, ADDR_DBL = 2'b10, ADDR_DBH = 2'b11).
  - The rx state enum (IDLE, START, DATA, STOP).
  - The default DATA_BITS/OVERSAMPLE constants, shared with the transmitter.
- One sub-module, spart_sync: a parameterised SYNC_STAGES flop chain with reset value 1. It is reusable for other async inputs.

Test Plan:
- Bench setup: BRGEN tied 1, so one bit = 16 clk.
- Send 0xAA as 8N1 -> after the stop sample: rec_buff = 8'hAA, RDA = 1, FE = 0, OE = 0. IOCS = 1, IORW = 1, IOADDR = 00 for one cycle -> RDA = 0.
- Send 0x55, then 0x3C without reading -> rec_buff = 8'h3C, RDA = 1, OE = 1. A buffer read clears both.
- Send 0x81 with the stop bit forced 0 -> FE = 1, RDA = 0, rec_buff unchanged. A status read (IOADDR = 01) -> FE = 0.
- Glitch: RxD low for 4 clk, then high -> no RDA/FE change; state back in IDLE. A following 0x0F frame is received correctly.
- Assert rst low during data bit 3 of 0xFF -> outputs at reset values immediately (async). After release, a frame of 0x12 -> rec_buff = 8'h12.
- BRGEN pulsing once every 4 clk with 0xC3 at the matching baud -> rec_buff = 8'hC3. A buffer read asserted on the completion edge -> RDA remains 1, OE = 0.
